// File: rtl/inst_fetch_bridge_mo_if.sv
// Fetch-side valid/ready and sram_like instruction-bus signals of the fetch bridge.
// slave = bridge view, master = CPU front end plus instruction bus view.
interface inst_fetch_bridge_mo_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              flush;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_addr_rdy;
   logic              fetch_data_vld;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_data_rdy;
   logic              fetch_busy;
   logic              inst_req;
   logic              inst_wr;
   logic [1:0]        inst_size;
   logic [31:0]       inst_addr;
   logic [31:0]       inst_wdata;
   logic [31:0]       inst_rdata;
   logic              inst_addr_ok;
   logic              inst_data_ok;

   modport slave (
      input  flush, fetch_req, fetch_addr, fetch_data_rdy, inst_rdata, inst_addr_ok, inst_data_ok,
      output fetch_addr_rdy, fetch_data_vld, fetch_data, fetch_busy,
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata
   );

   modport master (
      output flush, fetch_req, fetch_addr, fetch_data_rdy, inst_rdata, inst_addr_ok, inst_data_ok,
      input  fetch_addr_rdy, fetch_data_vld, fetch_data, fetch_busy,
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata
   );
endinterface

// File: rtl/inst_fetch_bridge_mo.sv
// Instruction-fetch bridge: up to DEPTH sram_like fetches in flight, response FIFO, flush discard.
// Define IFB_BYPASS_EN to forward a data_ok word straight to fetch_data when the FIFO is empty.
module inst_fetch_bridge_mo #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input logic                   clk,
   input logic                   rst,
   inst_fetch_bridge_mo_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

   typedef enum logic [0:0] {StIdle, StReq} state_e;

   state_e            r_state;
   logic [31:0]       r_addr;
   logic              r_stale;
   logic [CW-1:0]     r_inflight;
   logic [CW-1:0]     r_disc;
   logic [CW-1:0]     r_fcnt;
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_acc;
   logic              w_dok;
   logic              w_take;
   logic              w_push;
   logic              w_pop;
   logic              w_byp;
   logic              w_credit_idle;
   logic              w_credit_req;
   logic [CW:0]       w_occ;
   logic [CW-1:0]     w_inflight_n;
   logic [DATA_W-1:0] w_rword;

   assign w_rword       = bus.inst_rdata[DATA_W-1:0];
   assign w_occ         = {1'b0, r_inflight} + {1'b0, r_fcnt};
   assign w_credit_idle = w_occ < DepthW;
   // The request being accepted this cycle already holds one credit.
   assign w_credit_req  = (w_occ + (CW+1)'(1)) < DepthW;
   assign w_acc         = (r_state == StReq) && bus.inst_addr_ok;
   assign w_dok         = bus.inst_data_ok && (r_inflight != '0);

   assign bus.fetch_addr_rdy = !rst && !bus.flush &&
                               (((r_state == StIdle) && w_credit_idle) || (w_acc && w_credit_req));
   assign w_take = bus.fetch_req && bus.fetch_addr_rdy;

`ifdef IFB_BYPASS_EN
   assign w_byp = w_dok && (r_disc == '0) && (r_fcnt == '0) && !bus.flush && bus.fetch_data_rdy;
`else
   assign w_byp = 1'b0;
`endif

   assign w_push       = w_dok && (r_disc == '0) && !bus.flush && !w_byp;
   assign w_pop        = (r_fcnt != '0) && bus.fetch_data_rdy && !bus.flush;
   assign w_inflight_n = r_inflight + CW'(w_acc) - CW'(w_dok);

   assign bus.inst_req   = (r_state == StReq);
   assign bus.inst_addr  = r_addr;
   assign bus.inst_wr    = 1'b0;
   assign bus.inst_size  = 2'b10;
   assign bus.inst_wdata = '0;
   assign bus.fetch_busy = (r_state == StReq) || (r_inflight != '0) || (r_disc != '0) ||
                           (r_fcnt != '0);

`ifdef IFB_BYPASS_EN
   assign bus.fetch_data_vld = (r_fcnt != '0) || w_byp;
   assign bus.fetch_data     = (r_fcnt != '0) ? r_mem[r_rptr] : (w_byp ? w_rword : '0);
`else
   assign bus.fetch_data_vld = (r_fcnt != '0);
   assign bus.fetch_data     = (r_fcnt != '0) ? r_mem[r_rptr] : '0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_rword;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_addr     <= '0;
         r_stale    <= 1'b0;
         r_inflight <= '0;
         r_disc     <= '0;
         r_fcnt     <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
      end else begin
         r_inflight <= w_inflight_n;
         // On flush every response still owed, including one accepted now, becomes stale.
         if (bus.flush) begin
            r_disc <= w_inflight_n;
         end else begin
            r_disc <= r_disc - CW'(w_dok && (r_disc != '0)) + CW'(w_acc && r_stale);
         end

         if (bus.flush) begin
            r_fcnt <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
         end

         case (r_state)
            StIdle: begin
               if (w_take) begin
                  r_addr  <= 32'(bus.fetch_addr);
                  r_stale <= 1'b0;
                  r_state <= StReq;
               end
            end
            StReq: begin
               if (w_acc) begin
                  if (w_take) begin
                     r_addr  <= 32'(bus.fetch_addr);
                     r_stale <= 1'b0;
                  end else begin
                     r_state <= StIdle;
                  end
               end else if (bus.flush) begin
                  r_stale <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end
endmodule
